// File: rtl/task_deq_arbiter.sv
// Round-robin arbiter sharing one task-unit dequeue port among N_CORES cores.
// Define DEQ_ARB_STATS_EN to add per-core dequeue/timeout counters.
package task_deq_pkg;
  typedef logic [3:0] task_type_t;
  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] arg;
    task_type_t  ttype;
  } task_t;
  typedef logic [5:0] cq_slice_slot_t;
endpackage

module task_deq_arbiter
  import task_deq_pkg::*;
#(
  parameter int N_CORES  = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CORES-1:0]           core_arvalid,
  input  task_type_t [N_CORES-1:0]     core_araddr,
  output logic [N_CORES-1:0]           core_rvalid,
  output task_t                        core_rdata,
  output cq_slice_slot_t               core_rslot,
  output logic                         tq_arvalid,
  output task_type_t                   tq_araddr,
  input  logic                         tq_rvalid,
  input  task_t                        tq_rdata,
  input  cq_slice_slot_t               tq_rslot,
  input  logic [$clog2(N_CORES)-1:0]   stat_sel,
  output logic [31:0]                  stat_grants,
  output logic [31:0]                  stat_timeouts
);
  localparam int GW = $clog2(N_CORES);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {ARB, GRANT} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gnt, gnt_nxt, ptr, ptr_nxt, pick, idx, gnt_inc;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          found, hs, deq_ev, to_ev;

  assign core_rdata = tq_rdata;
  assign core_rslot = tq_rslot;
  assign gnt_inc    = (gnt == GW'(N_CORES - 1)) ? '0 : gnt + 1'b1;

  // First requester at or above ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      idx = GW'((int'(ptr) + i) % N_CORES);
      if (!found && core_arvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    ptr_nxt     = ptr;
    wait_nxt    = wait_cnt;
    tq_arvalid  = 1'b0;
    tq_araddr   = '0;
    core_rvalid = '0;
    hs          = 1'b0;
    deq_ev      = 1'b0;
    to_ev       = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (found) begin
            gnt_nxt   = pick;
            wait_nxt  = '0;
            state_nxt = GRANT;
          end
        end
        GRANT: begin
          tq_arvalid       = core_arvalid[gnt];
          tq_araddr        = core_araddr[gnt];
          hs               = tq_arvalid & tq_rvalid;
          core_rvalid[gnt] = hs;
          // Handshake beats withdrawal beats timeout.
          if (hs || !core_arvalid[gnt] || wait_cnt == WW'(MAX_WAIT - 1)) begin
            state_nxt = ARB;
            ptr_nxt   = gnt_inc;
            deq_ev    = hs;
            to_ev     = !hs && core_arvalid[gnt];
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      gnt      <= '0;
      ptr      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      ptr      <= ptr_nxt;
      wait_cnt <= wait_nxt;
    end
  end

`ifdef DEQ_ARB_STATS_EN
  logic [N_CORES-1:0][31:0] grants_all, touts_all;

  for (genvar c = 0; c < N_CORES; c++) begin : g_stat
    logic [31:0] g_q, t_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        g_q <= '0;
        t_q <= '0;
      end else begin
        if (deq_ev && gnt == GW'(c) && g_q != '1) g_q <= g_q + 1'b1;
        if (to_ev  && gnt == GW'(c) && t_q != '1) t_q <= t_q + 1'b1;
      end
    end
    assign grants_all[c] = g_q;
    assign touts_all[c]  = t_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants   <= '0;
      stat_timeouts <= '0;
    end else begin
      stat_grants   <= grants_all[stat_sel];
      stat_timeouts <= touts_all[stat_sel];
    end
  end
`else
  logic unused_stat;
  assign unused_stat   = deq_ev ^ to_ev ^ (^stat_sel);
  assign stat_grants   = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_task_deq_arbiter.sv
// Directed bench for task_deq_arbiter: stimulus pushes expected handshakes,
// a negedge monitor pops and checks whichever core_rvalid appears.
module tb_task_deq_arbiter;
  import task_deq_pkg::*;

  localparam int N  = 8;
  localparam int MW = 16;
`ifdef DEQ_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       core_arvalid;
  task_type_t [N-1:0] core_araddr;
  logic [N-1:0]       core_rvalid;
  task_t              core_rdata;
  cq_slice_slot_t     core_rslot;
  logic               tq_arvalid;
  task_type_t         tq_araddr;
  logic               tq_rvalid;
  task_t              tq_rdata;
  cq_slice_slot_t     tq_rslot;
  logic [2:0]         stat_sel;
  logic [31:0]        stat_grants, stat_timeouts;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int core;
    int at;
  } exp_t;
  exp_t sbq[$];

  task_deq_arbiter #(.N_CORES(N), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .core_arvalid(core_arvalid), .core_araddr(core_araddr),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_rslot(core_rslot),
    .tq_arvalid(tq_arvalid), .tq_araddr(tq_araddr),
    .tq_rvalid(tq_rvalid), .tq_rdata(tq_rdata), .tq_rslot(tq_rslot),
    .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic task_t mk_task(int c);
    task_t t;
    t.ts    = 32'(c) * 32'h9E3779B1;
    t.arg   = ~32'(c);
    t.ttype = 4'(c);
    return t;
  endfunction

  function automatic cq_slice_slot_t mk_slot(int c);
    return cq_slice_slot_t'(c * 7 + 3);
  endfunction

  // Task unit payload changes every cycle so a stale or wrong-cycle pass is visible.
  assign tq_rdata = mk_task(cyc);
  assign tq_rslot = mk_slot(cyc);

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(int c, int at);
    exp_t e;
    e.core = c;
    e.at   = at;
    sbq.push_back(e);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_rvalid !== '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", core_rvalid, 0);
        end else begin
          e = sbq.pop_front();
          chk("rvalid_vec", core_rvalid, 128'(1) << e.core);
          chk("rvalid_cycle", cyc, e.at);
          chk("rdata", core_rdata, mk_task(cyc));
          chk("rslot", core_rslot, mk_slot(cyc));
        end
      end
    end
  end

  task automatic at_cyc(int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    core_arvalid = '0;
    tq_rvalid    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rd_stat(int c, int g, int t);
    stat_sel = 3'(c);
    @(posedge clk);
    #1;
    chk($sformatf("stat_grants[%0d]", c), stat_grants, STATS ? g : 0);
    chk($sformatf("stat_timeouts[%0d]", c), stat_timeouts, STATS ? t : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1;
    stat_sel = '0;
    for (int i = 0; i < N; i++) core_araddr[i] = task_type_t'(i + 1);
    // Reset with every core asking and the task unit offering.
    core_arvalid = '1;
    tq_rvalid    = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_tq_arvalid", tq_arvalid, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_tq_araddr", tq_araddr, 0);
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    rd_stat(0, 0, 0);

    // Single requester: core 3, pulses every 2nd cycle from request+1.
    @(posedge clk); #1;
    c0 = cyc;
    core_arvalid[3] = 1'b1;
    tq_rvalid = 1'b1;
    for (int k = 0; k < 10; k++) push(3, c0 + 1 + 2 * k);
    at_cyc(c0 + 1); @(negedge clk);
    chk("single_arvalid", tq_arvalid, 1);
    chk("single_araddr", tq_araddr, 4);
    at_cyc(c0 + 2); @(negedge clk);
    chk("single_arb_gap", tq_arvalid, 0);
    at_cyc(c0 + 20);
    idle();
    rd_stat(3, 10, 0);
    rd_stat(2, 0, 0);

    // Fairness: everyone requests for 160 cycles.
    do_reset();
    @(posedge clk); #1;
    c0 = cyc;
    core_arvalid = '1;
    tq_rvalid = 1'b1;
    for (int k = 0; k < 80; k++) push(k % N, c0 + 1 + 2 * k);
    at_cyc(c0 + 160);
    idle();
    for (int c = 0; c < N; c++) rd_stat(c, 10, 0);

    // Timeout: core 0 waits on type 2 with nothing available, core 1 next.
    do_reset();
    @(posedge clk); #1;
    c0 = cyc;
    core_araddr[0] = 4'd2;
    core_araddr[1] = 4'd5;
    core_arvalid[0] = 1'b1;
    core_arvalid[1] = 1'b1;
    at_cyc(c0 + 1); @(negedge clk);
    chk("to_first_arvalid", tq_arvalid, 1);
    chk("to_first_araddr", tq_araddr, 2);
    at_cyc(c0 + 16); @(negedge clk);
    chk("to_last_arvalid", tq_arvalid, 1);
    at_cyc(c0 + 17); @(negedge clk);
    chk("to_arb_arvalid", tq_arvalid, 0);
    at_cyc(c0 + 18);
    tq_rvalid = 1'b1;
    push(1, c0 + 18);
    @(negedge clk);
    chk("to_next_araddr", tq_araddr, 5);
    at_cyc(c0 + 19);
    idle();
    rd_stat(0, 0, 1);
    rd_stat(1, 1, 0);

    // Withdrawal: core 5 drops on its 2nd grant cycle; ptr must move to 6.
    do_reset();
    @(posedge clk); #1;
    c0 = cyc;
    core_arvalid[5] = 1'b1;
    at_cyc(c0 + 1); @(negedge clk);
    chk("wd_grant_arvalid", tq_arvalid, 1);
    at_cyc(c0 + 2);
    core_arvalid[5] = 1'b0;
    @(negedge clk);
    chk("wd_drop_arvalid", tq_arvalid, 0);
    at_cyc(c0 + 3);
    core_arvalid[4] = 1'b1;
    core_arvalid[6] = 1'b1;
    tq_rvalid = 1'b1;
    push(6, c0 + 4);
    @(negedge clk);
    chk("wd_arb_arvalid", tq_arvalid, 0);
    at_cyc(c0 + 5);
    idle();
    rd_stat(5, 0, 0);
    rd_stat(6, 1, 0);

    // Handshake on the timeout cycle counts as a dequeue.
    do_reset();
    @(posedge clk); #1;
    c0 = cyc;
    core_arvalid[2] = 1'b1;
    at_cyc(c0 + 16);
    tq_rvalid = 1'b1;
    push(2, c0 + 16);
    at_cyc(c0 + 17);
    idle();
    rd_stat(2, 1, 0);

    // Reset mid-grant (ptr is 3 here, so core 4 holds the grant).
    @(posedge clk); #1;
    c0 = cyc;
    core_arvalid[0] = 1'b1;
    core_arvalid[4] = 1'b1;
    at_cyc(c0 + 1);
    rst = 1'b1;
    tq_rvalid = 1'b1;
    @(negedge clk);
    chk("rstmid_core_rvalid", core_rvalid, 0);
    chk("rstmid_tq_arvalid", tq_arvalid, 0);
    at_cyc(c0 + 2);
    rst = 1'b0;
    push(0, c0 + 3);
    @(negedge clk);
    chk("rstmid_arb_arvalid", tq_arvalid, 0);
    at_cyc(c0 + 4);
    idle();
    rd_stat(2, 0, 0);
    rd_stat(4, 0, 0);
    rd_stat(0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_leftover", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/task_deq_arbiter.md
# task_deq_arbiter

Round-robin arbiter that shares one task-unit dequeue port among `N_CORES` cores in a tile.
- Grants one core at a time and forwards that core's task-type request to the task unit.
- Returns `task_t` and CQ slot data to the granted core, using the same-cycle valid/valid handshake the cores already use.
- A per-grant wait limit moves the grant on when the queue has no task of the requested type, so one core waiting on an empty type cannot block the other cores.
- Sits between the tile's cores and the task queue / CQ dequeue interface.

## Interface
Parameters:
- `N_CORES`, 8: number of requesting cores; must be ≥2.
- `MAX_WAIT`, 16: cycles a grant may stay open without a dequeue before it is released; must be ≥1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `core_arvalid`  in  N_CORES: per-core dequeue request.
- `core_araddr`  in  N_CORES × `task_type_t`: per-core requested task type.
- `core_rvalid`  out  N_CORES: per-core dequeue success; one-hot or zero.
- `core_rdata`  out  `task_t`: dequeued task, broadcast to all cores; equals `tq_rdata`.
- `core_rslot`  out  `cq_slice_slot_t`: CQ slot, broadcast; equals `tq_rslot`.
- `tq_arvalid`  out  1: dequeue request to the task unit.
- `tq_araddr`  out  `task_type_t`: task type requested from the task unit.
- `tq_rvalid`  in  1: task unit has a matching task this cycle.
- `tq_rdata`  in  `task_t`: task from the task unit.
- `tq_rslot`  in  `cq_slice_slot_t`: slot from the task unit.
- `stat_sel`  in  $clog2(N_CORES): selects the core whose statistics are read.
- `stat_grants`  out  32: dequeue count of the selected core.
- `stat_timeouts`  out  32: timeout count of the selected core.

## Operation
- State machine with states ARB and GRANT. Registers: `state`, `gnt` ($clog2(N_CORES) bits), `ptr` (same width), `wait_cnt` ($clog2(MAX_WAIT+1) bits).
- ARB:
  - `tq_arvalid`=0.
  - If any `core_arvalid` is set: `gnt` ← first set index searching from `ptr` upward, wrapping modulo N_CORES; `wait_cnt` ← 0; go to GRANT.
  - If no request is set: stay in ARB.
- GRANT, combinational outputs:
  - `tq_arvalid` = `core_arvalid[gnt]`.
  - `tq_araddr` = `core_araddr[gnt]`.
  - `core_rvalid[gnt]` = `tq_arvalid & tq_rvalid`; all other bits of `core_rvalid` are 0.
- GRANT, exits in priority order; every exit sets `ptr` ← `gnt`+1 (wrapping N_CORES−1 → 0) and goes to ARB:
  1. Handshake (`tq_arvalid & tq_rvalid`).
  2. Requester withdrew (`!core_arvalid[gnt]`), e.g. core stopped or reset.
  3. `wait_cnt == MAX_WAIT−1`: timeout; increments that core's timeout count.
  - Otherwise: `wait_cnt` ← `wait_cnt`+1.
- A handshake on the timeout cycle counts as a dequeue, not a timeout.
- `core_rdata` and `core_rslot` are pure wires from `tq_rdata` and `tq_rslot`; only `core_rvalid` qualifies them.
- Reset, including reset mid-grant:
  - `state` = ARB, `gnt` = 0, `ptr` = 0, `wait_cnt` = 0, stats = 0.
  - All outputs 0 except the broadcast data wires.
  - A handshake in the reset cycle is not counted.

## Timing
- Arbitration costs 1 cycle (ARB), so the peak rate is one dequeue per 2 cycles.
- Request-to-grant latency: ≥1 cycle after `core_arvalid` rises, provided no other core holds the grant.
- Worst-case wait for a continuously requesting core: (N_CORES−1)×(MAX_WAIT+1) cycles.
- `tq_arvalid` never depends combinationally on `tq_rvalid`.
- `core_rvalid` depends on `tq_rvalid` combinationally (0-cycle path), matching the core's existing handshake.
- No registered data path exists; the task payload crosses in the handshake cycle.

## Configuration
- `DEQ_ARB_STATS_EN` defined:
  - Per-core 32-bit dequeue and timeout counters; they saturate at 0xFFFF_FFFF and clear on `rst`.
  - `stat_grants` and `stat_timeouts` are registered one cycle after `stat_sel`.
- `DEQ_ARB_STATS_EN` not defined: no counters; `stat_grants` = `stat_timeouts` = 0 constantly.

## Test plan
- Single requester: core 3 holds `core_arvalid`, `tq_rvalid`=1 constantly → `core_rvalid[3]` pulses every 2nd cycle, starting 1 cycle after request; `core_rvalid` is 0 for every other core.
- Fairness: all 8 cores request, `tq_rvalid`=1 → grant order is 0,1,…,7,0. Over 160 cycles each core gets 10 dequeues (`stat_grants` = 10 each with `DEQ_ARB_STATS_EN`).
- Timeout: core 0 requests type 2, `tq_rvalid`=0, MAX_WAIT=16 → grant held for exactly 16 GRANT cycles. Then ARB, then the grant goes to core 1 if it is requesting; core 0's `stat_timeouts` = 1.
- Withdrawal: core 5 granted, drops `core_arvalid` on the 2nd GRANT cycle → `tq_arvalid`=0 that cycle; next cycle ARB with `ptr`=6; no stat change.
- Simultaneous handshake and timeout: `tq_rvalid` rises on the 16th GRANT cycle → dequeue counted, timeout not counted; the core sees `core_rvalid`=1.
- Reset mid-grant: assert `rst` for 1 cycle in GRANT with `tq_rvalid`=1 → `core_rvalid` and `tq_arvalid` are 0 that cycle; the next grant starts from core 0; stats read 0.
